// File: rtl/axi4_stream_rr_arbiter_if.sv
// AXI4-Stream bundle used by the round-robin arbiter.
// Full signal set; master drives payload, slave drives tready.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep,
    output tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep,
    input  tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_rr_arbiter.sv
// Packet-granular round-robin AXI4-Stream arbiter, registered output.
// Option: AXI4_STREAM_RR_ARBITER_TID_EN puts the source index on tid.
module axi4_stream_rr_arbiter #(
  parameter int N_INPUTS    = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  axi4_stream_if.slave                pkt_i [N_INPUTS],
  axi4_stream_if.master               pkt_o,
  output logic [$clog2(N_INPUTS)-1:0] grant_o,
  output logic                        busy_o
);
  localparam int GW = $clog2(N_INPUTS);
  localparam int SW = TDATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] idx;
  logic          found;

  logic [N_INPUTS-1:0]    req;
  logic [N_INPUTS-1:0]    rdy;
  logic [TDATA_WIDTH-1:0] in_data [N_INPUTS];
  logic [SW-1:0]          in_strb [N_INPUTS];
  logic [SW-1:0]          in_keep [N_INPUTS];
  logic                   in_last [N_INPUTS];
  logic [TID_WIDTH-1:0]   in_tid  [N_INPUTS];
  logic [TDEST_WIDTH-1:0] in_dest [N_INPUTS];
  logic [TUSER_WIDTH-1:0] in_user [N_INPUTS];

  logic                   o_valid;
  logic [TDATA_WIDTH-1:0] o_data;
  logic [SW-1:0]          o_strb;
  logic [SW-1:0]          o_keep;
  logic                   o_last;
  logic [TID_WIDTH-1:0]   o_tid;
  logic [TDEST_WIDTH-1:0] o_dest;
  logic [TUSER_WIDTH-1:0] o_user;

  logic                 out_free;
  logic                 accept;
  logic [TID_WIDTH-1:0] sel_tid;

  for (genvar k = 0; k < N_INPUTS; k++) begin : g_in
    assign req[k]     = pkt_i[k].tvalid;
    assign in_data[k] = pkt_i[k].tdata;
    assign in_strb[k] = pkt_i[k].tstrb;
    assign in_keep[k] = pkt_i[k].tkeep;
    assign in_last[k] = pkt_i[k].tlast;
    assign in_tid[k]  = pkt_i[k].tid;
    assign in_dest[k] = pkt_i[k].tdest;
    assign in_user[k] = pkt_i[k].tuser;
    assign pkt_i[k].tready = rdy[k];
  end

`ifdef AXI4_STREAM_RR_ARBITER_TID_EN
  if (TID_WIDTH < GW) begin : g_tid_chk
    $fatal(1, "TID_WIDTH cannot hold a source index");
  end
  assign sel_tid = TID_WIDTH'(grant_q);
`else
  assign sel_tid = in_tid[grant_q];
`endif

  assign busy_o   = (state_q == BUSY);
  assign grant_o  = grant_q;
  assign out_free = !o_valid || pkt_o.tready;
  assign accept   = |(rdy & req);

  // only the granted source sees tready, and only if the output can take a beat
  always_comb begin
    rdy = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      rdy[k] = busy_o && (grant_q == GW'(k)) && out_free;
    end
  end

  // state and grant registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= GW'(N_INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // rotating search from grant+1 in IDLE; release after accepted tlast
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx     = '0;
    found   = 1'b0;
    unique case (state_q)
      IDLE: begin
        for (int i = 1; i <= N_INPUTS; i++) begin
          idx = GW'((int'(grant_q) + i) % N_INPUTS);
          if (!found && req[idx]) begin
            found   = 1'b1;
            grant_d = idx;
          end
        end
        if (found) state_d = BUSY;
      end
      BUSY: begin
        if (accept && in_last[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // output stage: load on accept, drain on tready, hold while stalled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_strb  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
      o_tid   <= '0;
      o_dest  <= '0;
      o_user  <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_data  <= in_data[grant_q];
      o_strb  <= in_strb[grant_q];
      o_keep  <= in_keep[grant_q];
      o_last  <= in_last[grant_q];
      o_tid   <= sel_tid;
      o_dest  <= in_dest[grant_q];
      o_user  <= in_user[grant_q];
    end else if (pkt_o.tready) begin
      o_valid <= 1'b0;
    end
  end

  assign pkt_o.tvalid = o_valid;
  assign pkt_o.tdata  = o_data;
  assign pkt_o.tstrb  = o_strb;
  assign pkt_o.tkeep  = o_keep;
  assign pkt_o.tlast  = o_last;
  assign pkt_o.tid    = o_tid;
  assign pkt_o.tdest  = o_dest;
  assign pkt_o.tuser  = o_user;
endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
// Bench for axi4_stream_rr_arbiter: packet-queue model, per-cycle compare,
// plus hand-computed timing/order tables for directed scenarios.
module tb_axi4_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  tid;
    logic        dest;
    logic        user;
  } beat_t;

  typedef struct packed {
    logic [31:0] cyc;
    beat_t       b;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(IW),
    .TDEST_WIDTH(1), .TUSER_WIDTH(1)) src [N] ();
  axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(IW),
    .TDEST_WIDTH(1), .TUSER_WIDTH(1)) snk ();

  logic [1:0] grant;
  logic       busy;

  axi4_stream_rr_arbiter #(
    .N_INPUTS(N), .TDATA_WIDTH(DW), .TID_WIDTH(IW),
    .TDEST_WIDTH(1), .TUSER_WIDTH(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pkt_i(src),
    .pkt_o(snk), .grant_o(grant), .busy_o(busy)
  );

  beat_t      mem [N][64];
  int         rp [N] = '{default: 0};
  int         wc [N] = '{default: 0};
  logic [N-1:0] en = '0;
  logic       o_ready = 1'b1;
  logic [N-1:0] rdy_v;
  beat_t      out_b;
  int         pkt_no = 0;

  for (genvar k = 0; k < N; k++) begin : g_src
    assign src[k].tvalid = en[k] && (rp[k] != wc[k]);
    assign src[k].tdata  = mem[k][rp[k]].data;
    assign src[k].tstrb  = mem[k][rp[k]].strb;
    assign src[k].tkeep  = mem[k][rp[k]].keep;
    assign src[k].tlast  = mem[k][rp[k]].last;
    assign src[k].tid    = mem[k][rp[k]].tid;
    assign src[k].tdest  = mem[k][rp[k]].dest;
    assign src[k].tuser  = mem[k][rp[k]].user;
    assign rdy_v[k]      = src[k].tready;
  end

  assign snk.tready = o_ready;
  assign out_b = {snk.tdata, snk.tstrb, snk.tkeep, snk.tlast,
                  snk.tid, snk.tdest, snk.tuser};

  // model state: packet owner, grant pointer, one-deep output queue
  bit         m_busy = 1'b0;
  logic [1:0] m_grant = 2'd3;
  beat_t      outq [$];
  ev_t        log_q [$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  int t2_off [12] = '{2, 3, 4, 6, 7, 8, 10, 11, 12, 14, 15, 16};
  int t2_src [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int t3_off [3]  = '{2, 4, 6};
  int t5_off [6]  = '{2, 3, 9, 10, 12, 13};
  int t5_src [6]  = '{1, 1, 1, 1, 3, 3};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit vld(input int k);
    return en[k] && (rp[k] != wc[k]);
  endfunction

  task automatic add_pkt(input int k, input int len, input logic [1:0] tid);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(k), 8'(pkt_no), 16'(i)};
      b.strb = 4'($urandom);
      b.keep = 4'($urandom);
      b.last = (i == len - 1);
      b.tid  = tid;
      b.dest = 1'($urandom);
      b.user = 1'($urandom);
      mem[k][wc[k]] = b;
      wc[k]++;
    end
    pkt_no++;
  endtask

  // one clock: compare at negedge, plan, commit just after posedge
  task automatic cycle();
    bit free, acc, pop, n_busy;
    logic [1:0] n_grant;
    logic [N-1:0] exp_rdy;
    beat_t b;
    int g;
    @(negedge clk);
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_grant = 2'(N - 1);
      outq.delete();
    end
    free = (outq.size() == 0) || o_ready;
    acc  = m_busy && vld(int'(m_grant)) && free;
    exp_rdy = '0;
    if (m_busy && free) exp_rdy[m_grant] = 1'b1;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("grant", 64'(grant), 64'(m_grant));
    chk("tready", 64'(rdy_v), 64'(exp_rdy));
    chk("tvalid", 64'(snk.tvalid), 64'(outq.size() != 0));
    if (outq.size() != 0) chk("beat", 64'(out_b), 64'(outq[0]));
    pop = (outq.size() != 0) && o_ready;
    if (pop) log_q.push_back('{32'(cyc), outq[0]});
    n_busy  = m_busy;
    n_grant = m_grant;
    if (m_busy) begin
      if (acc && mem[m_grant][rp[m_grant]].last) n_busy = 1'b0;
    end else begin
      for (int i = 1; i <= N; i++) begin
        g = (int'(m_grant) + i) % N;
        if (vld(g)) begin
          n_grant = 2'(g);
          n_busy  = 1'b1;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (pop) void'(outq.pop_front());
      if (acc) begin
        b = mem[m_grant][rp[m_grant]];
`ifdef AXI4_STREAM_RR_ARBITER_TID_EN
        b.tid = m_grant;
`endif
        outq.push_back(b);
        rp[m_grant]++;
      end
      m_busy  = n_busy;
      m_grant = n_grant;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = '0;
    o_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      rp[k] = 0;
      wc[k] = 0;
    end
    run(2);
    rst_n = 1'b1;
    run(1);
    log_q.delete();
  endtask

  task automatic chk_log(input string name, input int i,
                         input int off, input int s, input int c0);
    if (i < log_q.size()) begin
      chk({name, "_cyc"}, 64'(int'(log_q[i].cyc) - c0), 64'(off));
      chk({name, "_src"}, 64'(log_q[i].b.data[31:24]), 64'(s));
    end else begin
      chk({name, "_missing"}, 64'(log_q.size()), 64'(i + 1));
    end
  endtask

  initial begin
    int c0;
    int total;
    bit done;

    // all four sources at once: rotation order, one idle cycle between
    do_reset();
    for (int k = 0; k < N; k++) add_pkt(k, 3, 2'd0);
    en = '1;
    c0 = cyc;
    run(20);
    chk("t2_count", 64'(log_q.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk_log("t2", i, t2_off[i], t2_src[i], c0);

    // single source, back-to-back single-beat packets
    do_reset();
    for (int i = 0; i < 3; i++) add_pkt(2, 1, 2'd0);
    en = 4'b0100;
    c0 = cyc;
    run(10);
    chk("t3_count", 64'(log_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk_log("t3", i, t3_off[i], 2, c0);
    chk("t3_grant", 64'(grant), 64'd2);

    // granted source stalls mid-packet while another requests
    do_reset();
    add_pkt(1, 4, 2'd0);
    add_pkt(3, 2, 2'd0);
    en = 4'b0010;
    c0 = cyc;
    run(3);
    en = 4'b1000;
    run(5);
    en = 4'b1010;
    run(12);
    chk("t5_count", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk_log("t5", i, t5_off[i], t5_src[i], c0);

    // reset mid-packet truncates and restarts rotation at source 0
    do_reset();
    add_pkt(0, 4, 2'd0);
    en = 4'b0001;
    run(3);
    chk("t1_pre_valid", 64'(snk.tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", 64'(snk.tvalid), 64'd0);
    chk("t1_rst_data", 64'(snk.tdata), 64'd0);
    chk("t1_rst_last", 64'(snk.tlast), 64'd0);
    chk("t1_rst_busy", 64'(busy), 64'd0);
    chk("t1_rst_grant", 64'(grant), 64'd3);
    chk("t1_rst_tready", 64'(rdy_v), 64'd0);
    en = '0;
    rp[0] = wc[0];
    run(2);
    rst_n = 1'b1;
    log_q.delete();
    add_pkt(2, 1, 2'd0);
    add_pkt(0, 1, 2'd0);
    en = 4'b0101;
    run(8);
    chk("t1_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("t1_first", 64'(log_q[0].b.data[31:24]), 64'd0);
      chk("t1_second", 64'(log_q[1].b.data[31:24]), 64'd2);
    end

    // tid handling on source 2
    do_reset();
    add_pkt(2, 1, 2'd1);
    en = 4'b0100;
    run(6);
    chk("t6_count", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
`ifdef AXI4_STREAM_RR_ARBITER_TID_EN
      chk("t6_tid", 64'(log_q[0].b.tid), 64'd2);
`else
      chk("t6_tid", 64'(log_q[0].b.tid), 64'd1);
`endif
    end

    // random source valid and downstream backpressure
    do_reset();
    total = 0;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < 5; p++) begin
        int len;
        len = $urandom_range(1, 4);
        add_pkt(k, len, 2'($urandom));
        total += len;
      end
    end
    for (int i = 0; i < 300; i++) begin
      en      = 4'($urandom);
      o_ready = 1'($urandom);
      cycle();
    end
    en      = '1;
    o_ready = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      cycle();
      done = (outq.size() == 0) && !m_busy;
      for (int k = 0; k < N; k++) if (rp[k] != wc[k]) done = 1'b0;
    end
    chk("t4_drained", 64'(done), 64'd1);
    chk("t4_beats", 64'(log_q.size()), 64'(total));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
